// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RST_FLUSH = 2'd0,
        RUN       = 2'd1,
        MC_BUSY   = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forwarding selector; MEM result wins over WB, x0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_mem_i,
    input  logic              wen_mem_i,
    input  logic [REG_AW-1:0] rd_wb_i,
    input  logic              wen_wb_i,
    output logic [1:0]        fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (rs_i != '0) begin
            if (wen_mem_i && (rs_i == rd_mem_i)) begin
                fwd_o = FWD_MEM;
            end else if (wen_wb_i && (rs_i == rd_wb_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard, forwarding and sequenced pipeline-reset controller for the 5-stage RV32I core.
// Optional saturating perf counters are enabled with `define HAZ_PERF_CNT_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW           = 5,
    parameter int unsigned RST_FLUSH_CYCLES = 5,
    parameter int unsigned PERF_W           = 32
) (
    input  logic              clk,
    input  logic              processor_rst_n,
    input  logic              program_rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              RF_WENE,
    input  logic              RF_WENM,
    input  logic              RF_WENW,
    input  logic              sel_ldE_1,
    input  logic              br_taken,
    input  logic              mc_startE,
    input  logic              mc_doneE,
    output logic [1:0]        fwdAE,
    output logic [1:0]        fwdBE,
    output logic              Stall_IF,
    output logic              Stall_ID,
    output logic              Stall_EX,
    output logic              Flush_IF,
    output logic              Flush_ID,
    output logic              Flush_EX,
    output logic              Flush_MEM,
    output logic              Flush_WB,
    output logic              mc_abort,
    output logic              pipe_ready
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    localparam int unsigned        FCNT_W    = $clog2(RST_FLUSH_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(RST_FLUSH_CYCLES);

    hz_state_e         state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              ld_stall;
    logic [1:0]        fwd_a_raw, fwd_b_raw;

    // Forwarding

    fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .rs_i      (rs1E),
        .rd_mem_i  (rdM),
        .wen_mem_i (RF_WENM),
        .rd_wb_i   (rdW),
        .wen_wb_i  (RF_WENW),
        .fwd_o     (fwd_a_raw)
    );

    fwd_sel #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .rs_i      (rs2E),
        .rd_mem_i  (rdM),
        .wen_mem_i (RF_WENM),
        .rd_wb_i   (rdW),
        .wen_wb_i  (RF_WENW),
        .fwd_o     (fwd_b_raw)
    );

    // Selects are forced to the register file while the processor is held in reset.
    assign fwdAE = processor_rst_n ? fwd_a_raw : FWD_RF;
    assign fwdBE = processor_rst_n ? fwd_b_raw : FWD_RF;

    // Control FSM

    assign ld_stall = sel_ldE_1 & RF_WENE & (rdE != '0) & ((rs1D == rdE) | (rs2D == rdE));

    assign pipe_ready = (state_q == RUN) || (state_q == MC_BUSY);

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        Stall_IF  = 1'b0;
        Stall_ID  = 1'b0;
        Stall_EX  = 1'b0;
        Flush_IF  = 1'b0;
        Flush_ID  = 1'b0;
        Flush_EX  = 1'b0;
        Flush_MEM = 1'b0;
        Flush_WB  = 1'b0;
        mc_abort  = 1'b0;

        unique case (state_q)
            RST_FLUSH: begin
                Flush_IF  = 1'b1;
                Flush_ID  = 1'b1;
                Flush_EX  = 1'b1;
                Flush_MEM = 1'b1;
                Flush_WB  = 1'b1;
                fcnt_d    = fcnt_q - FCNT_W'(1);
                if (fcnt_q == FCNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A taken branch squashes the younger instructions, so any stall is moot.
                if (br_taken) begin
                    Flush_ID = 1'b1;
                    Flush_EX = 1'b1;
                end else if (mc_startE && !mc_doneE) begin
                    Stall_IF  = 1'b1;
                    Stall_ID  = 1'b1;
                    Stall_EX  = 1'b1;
                    Flush_MEM = 1'b1;
                    state_d   = MC_BUSY;
                end else if (ld_stall) begin
                    Stall_IF = 1'b1;
                    Stall_ID = 1'b1;
                    Flush_EX = 1'b1;
                end
            end
            MC_BUSY: begin
                if (mc_doneE) begin
                    state_d = RUN;
                end else begin
                    Stall_IF  = 1'b1;
                    Stall_ID  = 1'b1;
                    Stall_EX  = 1'b1;
                    Flush_MEM = 1'b1;
                end
            end
            default: begin
                state_d = RST_FLUSH;
                fcnt_d  = FCNT_INIT;
            end
        endcase

        if (program_rst) begin
            state_d   = RST_FLUSH;
            fcnt_d    = FCNT_INIT;
            Stall_IF  = 1'b0;
            Stall_ID  = 1'b0;
            Stall_EX  = 1'b0;
            Flush_IF  = 1'b1;
            Flush_ID  = 1'b1;
            Flush_EX  = 1'b1;
            Flush_MEM = 1'b1;
            Flush_WB  = 1'b1;
            mc_abort  = (state_q == MC_BUSY);
        end
    end

    always_ff @(posedge clk or negedge processor_rst_n) begin
        if (!processor_rst_n) begin
            state_q <= RST_FLUSH;
            fcnt_q  <= FCNT_INIT;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
    logic              br_flush;

    assign br_flush = (state_q == RUN) && br_taken && !program_rst;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall_IF && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (br_flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge processor_rst_n) begin
        if (!processor_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    logic unused_perf_w;
    assign unused_perf_w = |PERF_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: expected outputs queued per driven cycle, checked at negedge.
module tb_hazard_ctrl_unit;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_ALL  = 5'b11111;
    localparam logic [4:0] F_BR   = 5'b01100;
    localparam logic [4:0] F_LD   = 5'b00100;
    localparam logic [4:0] F_MC   = 5'b00010;
    localparam logic [2:0] S_NONE = 3'b000;
    localparam logic [2:0] S_LD   = 3'b110;
    localparam logic [2:0] S_MC   = 3'b111;

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [2:0] st;
        logic [4:0] fl;
        logic       ab;
        logic       rdy;
    } exp_t;

    logic       clk;
    logic       processor_rst_n;
    logic       program_rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       RF_WENE, RF_WENM, RF_WENW;
    logic       sel_ldE_1, br_taken, mc_startE, mc_doneE;
    logic [1:0] fwdAE, fwdBE;
    logic       Stall_IF, Stall_ID, Stall_EX;
    logic       Flush_IF, Flush_ID, Flush_EX, Flush_MEM, Flush_WB;
    logic       mc_abort, pipe_ready;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_ctrl_unit #(
        .REG_AW           (5),
        .RST_FLUSH_CYCLES (5),
        .PERF_W           (32)
    ) dut (
        .clk             (clk),
        .processor_rst_n (processor_rst_n),
        .program_rst     (program_rst),
        .rs1D            (rs1D),
        .rs2D            (rs2D),
        .rs1E            (rs1E),
        .rs2E            (rs2E),
        .rdE             (rdE),
        .rdM             (rdM),
        .rdW             (rdW),
        .RF_WENE         (RF_WENE),
        .RF_WENM         (RF_WENM),
        .RF_WENW         (RF_WENW),
        .sel_ldE_1       (sel_ldE_1),
        .br_taken        (br_taken),
        .mc_startE       (mc_startE),
        .mc_doneE        (mc_doneE),
        .fwdAE           (fwdAE),
        .fwdBE           (fwdBE),
        .Stall_IF        (Stall_IF),
        .Stall_ID        (Stall_ID),
        .Stall_EX        (Stall_EX),
        .Flush_IF        (Flush_IF),
        .Flush_ID        (Flush_ID),
        .Flush_EX        (Flush_EX),
        .Flush_MEM       (Flush_MEM),
        .Flush_WB        (Flush_WB),
        .mc_abort        (mc_abort),
        .pipe_ready      (pipe_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [1:0] fa, input logic [1:0] fb,
                                input logic [2:0] st, input logic [4:0] fl, input logic ab,
                                input logic rdy);
        exp_t e;
        e.name = name;
        e.fa   = fa;
        e.fb   = fb;
        e.st   = st;
        e.fl   = fl;
        e.ab   = ab;
        e.rdy  = rdy;
        return e;
    endfunction

    // Inputs for the current cycle are already applied; queue what must be seen, then advance.
    task automatic cycle(input exp_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        program_rst = 1'b0;
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        rdE = '0; rdM = '0; rdW = '0;
        RF_WENE = 1'b0; RF_WENM = 1'b0; RF_WENW = 1'b0;
        sel_ldE_1 = 1'b0; br_taken = 1'b0; mc_startE = 1'b0; mc_doneE = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq({e.name, "/fwdAE"}, 32'(fwdAE), 32'(e.fa));
            check_eq({e.name, "/fwdBE"}, 32'(fwdBE), 32'(e.fb));
            check_eq({e.name, "/stall"}, 32'({Stall_IF, Stall_ID, Stall_EX}), 32'(e.st));
            check_eq({e.name, "/flush"},
                     32'({Flush_IF, Flush_ID, Flush_EX, Flush_MEM, Flush_WB}), 32'(e.fl));
            check_eq({e.name, "/mc_abort"}, 32'(mc_abort), 32'(e.ab));
            check_eq({e.name, "/pipe_ready"}, 32'(pipe_ready), 32'(e.rdy));
        end
    end

    initial begin
        idle_inputs();
        processor_rst_n = 1'b0;
        @(posedge clk);
        #1;
        // In reset, forwarding must stay at RF even with a matching MEM producer.
        rs1E = 5'd3; rdM = 5'd3; RF_WENM = 1'b1;
        cycle(mk("reset", 2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        idle_inputs();
        processor_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(mk($sformatf("rst_flush%0d", i), 2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        end
        cycle(mk("run_idle", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));

        // Forwarding priority and x0 qualification.
        rs1E = 5'd3; rs2E = 5'd3; rdM = 5'd3; rdW = 5'd3; RF_WENM = 1'b1; RF_WENW = 1'b1;
        cycle(mk("fwd_mem", 2'b01, 2'b01, S_NONE, F_NONE, 1'b0, 1'b1));
        RF_WENM = 1'b0;
        cycle(mk("fwd_wb", 2'b10, 2'b10, S_NONE, F_NONE, 1'b0, 1'b1));
        rs1E = 5'd0; rdM = 5'd0; rdW = 5'd0; RF_WENM = 1'b1; rs2E = 5'd9;
        cycle(mk("fwd_x0", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        idle_inputs();

        // Load-use.
        sel_ldE_1 = 1'b1; RF_WENE = 1'b1; rdE = 5'd7; rs2D = 5'd7; rs1D = 5'd2;
        cycle(mk("ld_use", 2'b00, 2'b00, S_LD, F_LD, 1'b0, 1'b1));
        idle_inputs();
        cycle(mk("ld_after", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        sel_ldE_1 = 1'b1; RF_WENE = 1'b1; rdE = 5'd0; rs2D = 5'd0;
        cycle(mk("ld_rd_x0", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        rdE = 5'd7; rs1D = 5'd7; RF_WENE = 1'b0;
        cycle(mk("ld_no_wen", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        RF_WENE = 1'b1; br_taken = 1'b1;
        cycle(mk("ld_br", 2'b00, 2'b00, S_NONE, F_BR, 1'b0, 1'b1));
        idle_inputs();
        br_taken = 1'b1; mc_startE = 1'b1;
        cycle(mk("br_mc", 2'b00, 2'b00, S_NONE, F_BR, 1'b0, 1'b1));
        idle_inputs();
        cycle(mk("br_mc_after", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));

        // Multi-cycle op: start plus three busy cycles stall, done cycle releases.
        mc_startE = 1'b1;
        cycle(mk("mc_start", 2'b00, 2'b00, S_MC, F_MC, 1'b0, 1'b1));
        mc_startE = 1'b0;
        cycle(mk("mc_busy1", 2'b00, 2'b00, S_MC, F_MC, 1'b0, 1'b1));
        sel_ldE_1 = 1'b1; RF_WENE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
        cycle(mk("mc_busy_ld", 2'b00, 2'b00, S_MC, F_MC, 1'b0, 1'b1));
        idle_inputs();
        cycle(mk("mc_busy3", 2'b00, 2'b00, S_MC, F_MC, 1'b0, 1'b1));
        mc_doneE = 1'b1;
        cycle(mk("mc_done", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        idle_inputs();
        cycle(mk("mc_back_run", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        mc_startE = 1'b1; mc_doneE = 1'b1;
        cycle(mk("mc_single", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));
        idle_inputs();
        cycle(mk("mc_single_after", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));

        // program_rst during MC_BUSY aborts and restarts the flush sequence.
        mc_startE = 1'b1;
        cycle(mk("abort_start", 2'b00, 2'b00, S_MC, F_MC, 1'b0, 1'b1));
        mc_startE = 1'b0; program_rst = 1'b1;
        cycle(mk("abort_prst", 2'b00, 2'b00, S_NONE, F_ALL, 1'b1, 1'b1));
        program_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(mk($sformatf("abort_flush%0d", i), 2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        end
        cycle(mk("abort_run", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));

        // program_rst in RUN: flush, no abort.
        program_rst = 1'b1;
        cycle(mk("prst_run", 2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b1));
        program_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(mk($sformatf("prst_flush%0d", i), 2'b00, 2'b00, S_NONE, F_ALL, 1'b0, 1'b0));
        end
        cycle(mk("prst_run2", 2'b00, 2'b00, S_NONE, F_NONE, 1'b0, 1'b1));

        @(negedge clk);
        #1;
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
